hart_debug_ctrl: RTL
====================

# hart_debug_ctrl

Core-side responder for the Debug Module's core interface. Accepts halt and resume requests, stalls and drains the pipeline, and acknowledges the halt. While the hart is halted, it services abstract-command register reads and writes against the GPR file, the CSR file, and local `dcsr`/`dpc`. The block sits inside the core between the DM port and the pipeline/register-file ports.

## Interface
Parameters:
- `XPR_LEN`, default 32: data width of GPRs, CSRs, PC and debug data.
- `REG_IDX_W`, default 13: register index width. Debug-spec numbering: 0x0000–0x0FFF are CSRs, 0x1000–0x101F are GPRs.

Ports:
- `clk` in 1: single clock. All logic is posedge.
- `reset` in 1: asynchronous, active-low reset.
- `haltreq` in 1: level halt request from the DM.
- `resumereq` in 1: level resume request from the DM.
- `core_haltack` out 1: high while the hart is halted.
- `resumeack` out 1: one-cycle pulse when a resume is taken.
- `register_index` in REG_IDX_W: register targeted by the access.
- `debug_read` in 1: read request, held high until `reg_rack`.
- `debug_write` in 1: write request, held high until `reg_wack`.
- `debug_wdata` in XPR_LEN: write data.
- `debug_rdata` out XPR_LEN: registered read data, valid with `reg_rack`.
- `reg_rack` out 1: read acknowledge, one-cycle pulse.
- `reg_wack` out 1: write acknowledge, one-cycle pulse.
- `stall_req` out 1: freeze fetch and drain the pipeline.
- `pipe_idle` in 1: pipeline empty, no instruction in flight.
- `core_pc` in XPR_LEN: PC of the next instruction to execute.
- `instr_retired` in 1: one instruction retired this cycle.
- `pc_redirect` out 1: one-cycle pulse that loads `resume_pc` into fetch.
- `resume_pc` out XPR_LEN: equals `dpc`.
- `gpr_addr` out 5, `gpr_we` out 1, `gpr_wdata` out XPR_LEN, `gpr_rdata` in XPR_LEN: GPR file debug port. The read port is combinational.
- `csr_addr` out 12, `csr_we` out 1, `csr_wdata` out XPR_LEN, `csr_rdata` in XPR_LEN: CSR file debug port. The read port is combinational.

## Operation
States: RUNNING, HALT_WAIT, HALTED, ACCESS, ACK_WAIT, RESUMING, STEPPING (the last only with the configuration macro).

- **RUNNING.** `haltreq`=1 moves to HALT_WAIT. `resumereq`, `debug_read` and `debug_write` are ignored here.
- **HALT_WAIT.** `stall_req`=1.
  - When `pipe_idle`=1: `dpc`←`core_pc`, `dcsr.cause`←3, then go to HALTED.
  - `haltreq` dropping here does not abort the halt.
- **HALTED.** `stall_req`=1 and `core_haltack`=1.
  - `debug_read` or `debug_write`: latch the index, data and direction, then go to ACCESS. Write has priority if both are high.
  - Otherwise, `resumereq`=1 and `haltreq`=0: go to RESUMING. If `haltreq` is also high, the block stays in HALTED.
- **ACCESS.** One cycle. The latched index is decoded as follows:
  - 0x1000–0x101F: GPR[index[4:0]]. A write to x0 is dropped; a read of x0 returns 0.
  - 0x07B0: local `dcsr`. Reads `{4'd4, 19'b0, cause[2:0], 3'b0, step, 2'b11}`. Only `step` is writable.
  - 0x07B1: local `dpc`. Full read/write.
  - Other 0x0000–0x0FFF: CSR file port.
  - Anything else: read returns 0, write is dropped.
  - In this cycle: `gpr_we`/`csr_we` pulse for writes, and `debug_rdata` is registered for reads.
  - Then go to ACK_WAIT.
- **ACK_WAIT.** `reg_rack` or `reg_wack` is high in the first ACK_WAIT cycle only. The state holds until `debug_read`=`debug_write`=0, then returns to HALTED. This prevents a still-high request from re-triggering the access.
- **RESUMING.** One cycle: `pc_redirect`=1 and `resumeack`=1. `stall_req` drops. Next state is RUNNING, or STEPPING if `dcsr.step`=1.
- `core_haltack` is high in HALTED, ACCESS, ACK_WAIT and RESUMING.

## Timing
- Reset values: all outputs 0, state RUNNING, `dpc`=0, `dcsr.cause`=0, `dcsr.step`=0.
- Reset mid-operation returns the block to RUNNING immediately. Any pending ack is lost.
- Halt latency: `haltreq` high at edge N gives `stall_req` high from N+1. `core_haltack` rises one cycle after the first `pipe_idle` sampled in HALT_WAIT.
- Access latency: request sampled in HALTED at edge N, ACCESS at N+1, ack pulse and valid `debug_rdata` at N+2. `debug_rdata` holds its value until the next read.
- Resume latency: `resumereq` sampled at N, `resumeack`/`pc_redirect` at N+1, RUNNING at N+2.
- `debug_rdata` is zero-extended. Write data is taken as-is.

## Configuration
- `DEBUG_STEP_EN` defined:
  - `dcsr.step` is writable.
  - After a resume with step=1, the block enters STEPPING with `stall_req`=0.
  - On the first `instr_retired`=1, `stall_req` asserts and the block goes to HALT_WAIT with `cause`←4.
  - A `haltreq` during STEPPING also goes to HALT_WAIT, with `cause`←3.
- Undefined: `dcsr.step` reads 0 and writes to it are ignored. There is no STEPPING state and `instr_retired` is unused.

## Test plan
- Halt: `haltreq`=1, `pipe_idle` delayed 5 cycles, `core_pc`=0x80000040 → `stall_req` high throughout; `core_haltack` high one cycle after `pipe_idle`; a read of 0x07B1 returns 0x80000040.
- GPR write/read: write 0x1005 with 0xDEADBEEF → `gpr_we` pulses with `gpr_addr`=5 and `reg_wack` pulses once. A read of 0x1005 with `gpr_rdata`=0xDEADBEEF → `reg_rack` pulses and `debug_rdata`=0xDEADBEEF.
- Held request: `debug_read` held 4 cycles past `reg_rack` → exactly one `reg_rack` pulse; no second access.
- x0 and unmapped: write 0x1000 → no `gpr_we`, `reg_wack`=1. Read 0x2000 → `debug_rdata`=0.
- Resume: write `dpc`=0x100, assert `resumereq` → `pc_redirect`=1 with `resume_pc`=0x100 and `resumeack`=1 for one cycle, then RUNNING. `haltreq`+`resumereq` together → stays halted.
- Step (`DEBUG_STEP_EN`): set step=1, resume, pulse `instr_retired` → re-halt; `dcsr` reads with cause=4 and step=1.

Source files
------------

// File: rtl/hart_debug_ctrl.sv
// hart_debug_ctrl
//   Core-side responder for the Debug Module core interface. Takes halt and
//   resume requests, stalls and drains the pipeline, acknowledges the halt,
//   and while halted services abstract register reads/writes against the GPR
//   file, the CSR file and the local dcsr/dpc registers.
//
// Optional feature macro: DEBUG_STEP_EN (single-step support via dcsr.step).
//
// Ports
//   clk, reset           : clock; asynchronous active-low reset
//   haltreq, resumereq   : level requests from the DM
//   core_haltack         : high while the hart is halted
//   resumeack            : one-cycle pulse when a resume is taken
//   register_index       : debug-spec register number (CSR 0x000-0xFFF, GPR 0x1000-0x101F)
//   debug_read/write     : access requests, held until reg_rack/reg_wack
//   debug_wdata          : write data
//   debug_rdata          : registered read data, valid with reg_rack
//   reg_rack, reg_wack   : one-cycle access acknowledges
//   stall_req            : freeze fetch and drain the pipeline
//   pipe_idle            : pipeline empty
//   core_pc              : PC of the next instruction to execute
//   instr_retired        : one instruction retired this cycle (step mode only)
//   pc_redirect          : one-cycle pulse loading resume_pc into fetch
//   resume_pc            : current dpc
//   gpr_*                : GPR file debug port (combinational read)
//   csr_*                : CSR file debug port (combinational read)
module hart_debug_ctrl #(
    parameter int unsigned XPR_LEN   = 32,
    parameter int unsigned REG_IDX_W = 13
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 haltreq,
    input  logic                 resumereq,
    output logic                 core_haltack,
    output logic                 resumeack,
    input  logic [REG_IDX_W-1:0] register_index,
    input  logic                 debug_read,
    input  logic                 debug_write,
    input  logic [XPR_LEN-1:0]   debug_wdata,
    output logic [XPR_LEN-1:0]   debug_rdata,
    output logic                 reg_rack,
    output logic                 reg_wack,
    output logic                 stall_req,
    input  logic                 pipe_idle,
    input  logic [XPR_LEN-1:0]   core_pc,
    input  logic                 instr_retired,
    output logic                 pc_redirect,
    output logic [XPR_LEN-1:0]   resume_pc,
    output logic [4:0]           gpr_addr,
    output logic                 gpr_we,
    output logic [XPR_LEN-1:0]   gpr_wdata,
    input  logic [XPR_LEN-1:0]   gpr_rdata,
    output logic [11:0]          csr_addr,
    output logic                 csr_we,
    output logic [XPR_LEN-1:0]   csr_wdata,
    input  logic [XPR_LEN-1:0]   csr_rdata
);

    typedef enum logic [2:0] {
        RUNNING,
        HALT_WAIT,
        HALTED,
        ACCESS,
        ACK_WAIT,
        RESUMING
`ifdef DEBUG_STEP_EN
        , STEPPING
`endif
    } state_e;

    state_e                 state_q, state_d;
    logic [XPR_LEN-1:0]     dpc_q, dpc_d;
    logic [2:0]             cause_q, cause_d;
    logic [REG_IDX_W-1:0]   idx_q, idx_d;
    logic [XPR_LEN-1:0]     wdata_q, wdata_d;
    logic                   wr_q, wr_d;
    logic [XPR_LEN-1:0]     rdata_q, rdata_d;
    logic                   rack_q, rack_d;
    logic                   wack_q, wack_d;

`ifdef DEBUG_STEP_EN
    logic                   step_q, step_d;
    logic [2:0]             hcause_q, hcause_d;  // cause to record when HALT_WAIT completes
`else
    logic                   step_q;
    logic                   unused_instr_retired;
    assign step_q               = 1'b0;
    assign unused_instr_retired = instr_retired;
`endif

    // Register decode of the latched index
    logic [31:0]        idx_ext;
    logic               is_gpr, is_dcsr, is_dpc, is_csr, is_x0;
    logic [31:0]        dcsr_rd;
    logic [XPR_LEN-1:0] rd_val;

    assign idx_ext = 32'(idx_q);
    assign is_gpr  = (idx_ext[31:5] == 27'h80);
    assign is_dcsr = (idx_ext == 32'h0000_07B0);
    assign is_dpc  = (idx_ext == 32'h0000_07B1);
    assign is_csr  = (idx_ext < 32'h0000_1000) && !is_dcsr && !is_dpc;
    assign is_x0   = (idx_q[4:0] == 5'd0);
    assign dcsr_rd = {4'd4, 19'b0, cause_q, 3'b0, step_q, 2'b11};

    always_comb begin
        rd_val = '0;
        if (is_gpr)       rd_val = is_x0 ? '0 : gpr_rdata;
        else if (is_dcsr) rd_val = XPR_LEN'(dcsr_rd);
        else if (is_dpc)  rd_val = dpc_q;
        else if (is_csr)  rd_val = csr_rdata;
    end

    always_comb begin
        state_d      = state_q;
        dpc_d        = dpc_q;
        cause_d      = cause_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        wr_d         = wr_q;
        rdata_d      = rdata_q;
        rack_d       = 1'b0;
        wack_d       = 1'b0;
        stall_req    = 1'b0;
        core_haltack = 1'b0;
        resumeack    = 1'b0;
        pc_redirect  = 1'b0;
        gpr_we       = 1'b0;
        csr_we       = 1'b0;
`ifdef DEBUG_STEP_EN
        step_d       = step_q;
        hcause_d     = hcause_q;
`endif
        unique case (state_q)
            RUNNING: begin
                if (haltreq) begin
                    state_d = HALT_WAIT;
`ifdef DEBUG_STEP_EN
                    hcause_d = 3'd3;
`endif
                end
            end
            HALT_WAIT: begin
                stall_req = 1'b1;
                if (pipe_idle) begin
                    dpc_d   = core_pc;
`ifdef DEBUG_STEP_EN
                    cause_d = hcause_q;
`else
                    cause_d = 3'd3;
`endif
                    state_d = HALTED;
                end
            end
            HALTED: begin
                stall_req    = 1'b1;
                core_haltack = 1'b1;
                if (debug_write || debug_read) begin
                    idx_d   = register_index;
                    wdata_d = debug_wdata;
                    wr_d    = debug_write;
                    state_d = ACCESS;
                end else if (resumereq && !haltreq) begin
                    state_d = RESUMING;
                end
            end
            ACCESS: begin
                stall_req    = 1'b1;
                core_haltack = 1'b1;
                if (wr_q) begin
                    gpr_we = is_gpr && !is_x0;
                    csr_we = is_csr;
                    if (is_dpc) dpc_d = wdata_q;
`ifdef DEBUG_STEP_EN
                    if (is_dcsr) step_d = wdata_q[2];
`endif
                    wack_d = 1'b1;
                end else begin
                    rdata_d = rd_val;
                    rack_d  = 1'b1;
                end
                state_d = ACK_WAIT;
            end
            ACK_WAIT: begin
                // Wait for the request to drop so a held request cannot re-trigger
                stall_req    = 1'b1;
                core_haltack = 1'b1;
                if (!debug_read && !debug_write) state_d = HALTED;
            end
            RESUMING: begin
                core_haltack = 1'b1;
                resumeack    = 1'b1;
                pc_redirect  = 1'b1;
`ifdef DEBUG_STEP_EN
                state_d = step_q ? STEPPING : RUNNING;
`else
                state_d = RUNNING;
`endif
            end
`ifdef DEBUG_STEP_EN
            STEPPING: begin
                // An external halt takes precedence over the step completion
                if (haltreq) begin
                    hcause_d = 3'd3;
                    state_d  = HALT_WAIT;
                end else if (instr_retired) begin
                    hcause_d = 3'd4;
                    state_d  = HALT_WAIT;
                end
            end
`endif
            default: state_d = RUNNING;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= RUNNING;
            dpc_q    <= '0;
            cause_q  <= '0;
            idx_q    <= '0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
            rdata_q  <= '0;
            rack_q   <= 1'b0;
            wack_q   <= 1'b0;
`ifdef DEBUG_STEP_EN
            step_q   <= 1'b0;
            hcause_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            dpc_q    <= dpc_d;
            cause_q  <= cause_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            wr_q     <= wr_d;
            rdata_q  <= rdata_d;
            rack_q   <= rack_d;
            wack_q   <= wack_d;
`ifdef DEBUG_STEP_EN
            step_q   <= step_d;
            hcause_q <= hcause_d;
`endif
        end
    end

    assign debug_rdata = rdata_q;
    assign reg_rack    = rack_q;
    assign reg_wack    = wack_q;
    assign resume_pc   = dpc_q;
    assign gpr_addr    = idx_q[4:0];
    assign gpr_wdata   = wdata_q;
    assign csr_addr    = idx_q[11:0];
    assign csr_wdata   = wdata_q;

endmodule
